// File: rtl/store_checker.sv
// rtl/store_checker.sv - compares core stores against a programmed table of expected stores
module store_checker #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 4,
    parameter int IGN_ADR     = 96,
    parameter int ORDERED     = 1,
    parameter int TIMEOUT_CYC = 1000,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [XLEN-1:0]  DataAdr,
    input  logic [XLEN-1:0]  WriteData,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [XLEN-1:0]  cfg_adr,
    input  logic [XLEN-1:0]  cfg_data,
    input  logic             start,
    input  logic [IDX_W:0]   num_exp,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [XLEN-1:0]  fail_adr,
    output logic [IDX_W:0]   match_cnt,
    output logic [7:0]       ign_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;
    localparam logic [1:0] ST_FAIL  = 2'd3;

    localparam int              CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W:0]  DEPTH_L = (IDX_W + 1)'(DEPTH);
    localparam logic [XLEN-1:0] IGN_L   = XLEN'(IGN_ADR);
    localparam logic [CW-1:0]   TMO_L   = CW'(TIMEOUT_CYC);

    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_adr  [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [DEPTH-1:0] r_hit;
    logic [IDX_W:0]   r_num_exp;
    logic [IDX_W:0]   r_match_cnt;
    logic [7:0]       r_ign_cnt;
    logic [CW-1:0]    r_cyc;
    logic [1:0]       r_fail_code;
    logic [XLEN-1:0]  r_fail_adr;

    logic             w_match;
    logic [IDX_W-1:0] w_hit_idx;
    logic [IDX_W:0]   w_match_next;
    logic [CW-1:0]    w_cyc_next;
    logic             w_timeout;

    // Unordered search walks downward so the lowest matching unhit entry wins.
    always_comb begin
        w_match   = 1'b0;
        w_hit_idx = '0;
        if (ORDERED != 0) begin
            w_hit_idx = r_match_cnt[IDX_W-1:0];
            w_match   = (r_match_cnt < r_num_exp) &&
                        (DataAdr == r_adr[w_hit_idx]) &&
                        (WriteData == r_data[w_hit_idx]);
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!r_hit[i] && ((IDX_W + 1)'(i) < r_num_exp) &&
                    (DataAdr == r_adr[i]) && (WriteData == r_data[i])) begin
                    w_match   = 1'b1;
                    w_hit_idx = IDX_W'(i);
                end
            end
        end
    end

    assign w_match_next = r_match_cnt + (IDX_W + 1)'(1);
    assign w_cyc_next   = r_cyc + CW'(1);
    assign w_timeout    = (w_cyc_next >= TMO_L);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_hit       <= '0;
            r_num_exp   <= '0;
            r_match_cnt <= '0;
            r_ign_cnt   <= '0;
            r_cyc       <= '0;
            r_fail_code <= '0;
            r_fail_adr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_adr[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (r_state == ST_CHECK) begin
            r_cyc <= w_cyc_next;
            if (MemWrite && w_match) begin
                r_hit[w_hit_idx] <= 1'b1;
                r_match_cnt      <= w_match_next;
                // Final match beats a coincident timeout.
                if (w_match_next == r_num_exp) begin
                    r_state <= ST_PASS;
                end else if (w_timeout) begin
                    r_state     <= ST_FAIL;
                    r_fail_code <= 2'd2;
                end
            end else if (MemWrite && (DataAdr != IGN_L)) begin
                r_state     <= ST_FAIL;
                r_fail_code <= 2'd1;
                r_fail_adr  <= DataAdr;
            end else begin
                if (MemWrite && (r_ign_cnt != 8'hFF)) begin
                    r_ign_cnt <= r_ign_cnt + 8'd1;
                end
                if (w_timeout) begin
                    r_state     <= ST_FAIL;
                    r_fail_code <= 2'd2;
                end
            end
        end else begin
            if (cfg_we && ({1'b0, cfg_idx} < DEPTH_L)) begin
                r_adr[cfg_idx]  <= cfg_adr;
                r_data[cfg_idx] <= cfg_data;
            end
            if (start) begin
                r_hit       <= '0;
                r_num_exp   <= num_exp;
                r_match_cnt <= '0;
                r_ign_cnt   <= '0;
                r_cyc       <= '0;
                r_fail_adr  <= '0;
                if (num_exp == '0) begin
                    r_state     <= ST_PASS;
                    r_fail_code <= 2'd0;
                end else if (num_exp > DEPTH_L) begin
                    r_state     <= ST_FAIL;
                    r_fail_code <= 2'd3;
                end else begin
                    r_state     <= ST_CHECK;
                    r_fail_code <= 2'd0;
                end
            end
        end
    end

    assign busy      = (r_state == ST_CHECK);
    assign pass      = (r_state == ST_PASS);
    assign fail      = (r_state == ST_FAIL);
    assign fail_code = r_fail_code;
    assign fail_adr  = r_fail_adr;
    assign match_cnt = r_match_cnt;
    assign ign_cnt   = r_ign_cnt;

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - ordered and unordered store_checker against a behavioural model
module tb_store_checker;

    localparam int TMO = 10;
    localparam int M_IDLE = 0, M_CHECK = 1, M_PASS = 2, M_FAIL = 3;

    logic        clk = 1'b0;
    logic        reset, mem_write, cfg_we, start;
    logic [31:0] data_adr, write_data, cfg_adr, cfg_data;
    logic [1:0]  cfg_idx;
    logic [2:0]  num_exp;

    logic [1:0]  busy_v, pass_v, fail_v;
    logic [1:0]  fcode_v [2];
    logic [31:0] fadr_v  [2];
    logic [2:0]  mcnt_v  [2];
    logic [7:0]  icnt_v  [2];

    int n_cmp = 0;
    int n_err = 0;

    // index 0 = ordered instance, index 1 = unordered instance
    int          st    [2];
    int          mcnt  [2];
    int          icnt  [2];
    int          cyc   [2];
    int          fcode [2];
    int          nexp  [2];
    logic [31:0] fadr  [2];
    logic [31:0] tadr  [2][4];
    logic [31:0] tdat  [2][4];
    bit          hit   [2][4];

    always #5 clk = ~clk;

    store_checker #(.XLEN(32), .DEPTH(4), .IGN_ADR(96), .ORDERED(1), .TIMEOUT_CYC(TMO)) u_ord (
        .clk(clk), .reset(reset), .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .start(start), .num_exp(num_exp), .busy(busy_v[0]), .pass(pass_v[0]), .fail(fail_v[0]),
        .fail_code(fcode_v[0]), .fail_adr(fadr_v[0]), .match_cnt(mcnt_v[0]), .ign_cnt(icnt_v[0])
    );

    store_checker #(.XLEN(32), .DEPTH(4), .IGN_ADR(96), .ORDERED(0), .TIMEOUT_CYC(TMO)) u_unord (
        .clk(clk), .reset(reset), .MemWrite(mem_write), .DataAdr(data_adr), .WriteData(write_data),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
        .start(start), .num_exp(num_exp), .busy(busy_v[1]), .pass(pass_v[1]), .fail(fail_v[1]),
        .fail_code(fcode_v[1]), .fail_adr(fadr_v[1]), .match_cnt(mcnt_v[1]), .ign_cnt(icnt_v[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                st[m] = M_IDLE; mcnt[m] = 0; icnt[m] = 0; cyc[m] = 0;
                fcode[m] = 0; fadr[m] = 0; nexp[m] = 0;
                for (int i = 0; i < 4; i++) begin
                    tadr[m][i] = 0; tdat[m][i] = 0; hit[m][i] = 0;
                end
            end else if (st[m] != M_CHECK) begin
                if (cfg_we) begin
                    tadr[m][cfg_idx] = cfg_adr;
                    tdat[m][cfg_idx] = cfg_data;
                end
                if (start) begin
                    mcnt[m] = 0; icnt[m] = 0; cyc[m] = 0; fcode[m] = 0; fadr[m] = 0;
                    for (int i = 0; i < 4; i++) hit[m][i] = 0;
                    nexp[m] = int'(num_exp);
                    if (nexp[m] == 0) st[m] = M_PASS;
                    else if (nexp[m] > 4) begin st[m] = M_FAIL; fcode[m] = 3; end
                    else st[m] = M_CHECK;
                end
            end else begin
                int k;
                k = -1;
                cyc[m]++;
                if (mem_write) begin
                    if (m == 0) begin
                        if (mcnt[m] < nexp[m] && tadr[m][mcnt[m]] == data_adr &&
                            tdat[m][mcnt[m]] == write_data) k = mcnt[m];
                    end else begin
                        for (int i = 0; i < nexp[m]; i++)
                            if (k < 0 && !hit[m][i] && tadr[m][i] == data_adr &&
                                tdat[m][i] == write_data) k = i;
                    end
                    if (k >= 0) begin
                        hit[m][k] = 1;
                        mcnt[m]++;
                        if (mcnt[m] == nexp[m]) st[m] = M_PASS;
                    end else if (data_adr == 96) begin
                        if (icnt[m] < 255) icnt[m]++;
                    end else begin
                        st[m] = M_FAIL; fcode[m] = 1; fadr[m] = data_adr;
                    end
                end
                if (st[m] == M_CHECK && cyc[m] >= TMO) begin
                    st[m] = M_FAIL; fcode[m] = 2;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("busy%0d", m), busy_v[m], st[m] == M_CHECK);
            check_eq($sformatf("pass%0d", m), pass_v[m], st[m] == M_PASS);
            check_eq($sformatf("fail%0d", m), fail_v[m], st[m] == M_FAIL);
            check_eq($sformatf("fail_code%0d", m), fcode_v[m], fcode[m]);
            check_eq($sformatf("fail_adr%0d", m), fadr_v[m], fadr[m]);
            check_eq($sformatf("match_cnt%0d", m), mcnt_v[m], mcnt[m]);
            check_eq($sformatf("ign_cnt%0d", m), icnt_v[m], icnt[m]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        reset = 0; mem_write = 0; cfg_we = 0; start = 0;
    endtask

    task automatic do_reset();
        reset = 1; cycle();
    endtask

    task automatic do_cfg(input int idx, input int adr, input int dat);
        cfg_we = 1; cfg_idx = 2'(idx); cfg_adr = adr; cfg_data = dat; cycle();
    endtask

    task automatic do_start(input int n);
        start = 1; num_exp = 3'(n); cycle();
    endtask

    task automatic do_store(input int adr, input int dat);
        mem_write = 1; data_adr = adr; write_data = dat; cycle();
    endtask

    initial begin
        reset = 1; mem_write = 0; cfg_we = 0; start = 0;
        data_adr = 0; write_data = 0; cfg_adr = 0; cfg_data = 0; cfg_idx = 0; num_exp = 0;

        // reset state and directed scenarios
        cycle();
        check_eq("rst_busy", busy_v, 2'b00);
        check_eq("rst_pass", pass_v, 2'b00);

        do_cfg(0, 96, 3); do_cfg(1, 100, 7); do_start(2);
        do_store(96, 3); do_store(100, 7);
        check_eq("ord2_mcnt", mcnt_v[0], 2);
        check_eq("ord2_pass", pass_v[0], 1);

        do_reset();
        do_cfg(0, 100, 7); do_start(1);
        do_store(96, 5); do_store(96, 9); do_store(100, 7);
        check_eq("ign_cnt", icnt_v[0], 2);
        check_eq("ign_pass", pass_v[0], 1);

        do_start(1); do_store(104, 7);
        check_eq("bad_fail", fail_v[0], 1);
        check_eq("bad_code", fcode_v[0], 1);
        check_eq("bad_adr", fadr_v[0], 104);
        do_start(1);
        check_eq("restart_busy", busy_v[0], 1);
        check_eq("restart_fail", fail_v[0], 0);

        do_reset();
        do_cfg(0, 100, 7); do_cfg(1, 200, 9); do_start(2);
        do_store(200, 9); do_store(100, 7);
        check_eq("unord_pass", pass_v[1], 1);
        check_eq("ord_swap_code", fcode_v[0], 1);
        check_eq("ord_swap_adr", fadr_v[0], 200);

        do_start(1);
        for (int i = 0; i < TMO - 1; i++) cycle();
        check_eq("tmo_busy_before", busy_v, 2'b11);
        cycle();
        check_eq("tmo_code", fcode_v[0], 2);
        check_eq("tmo_fail", fail_v, 2'b11);

        do_start(2); cycle(); cycle(); do_reset();
        check_eq("midrst_busy", busy_v, 2'b00);
        check_eq("midrst_fail", fail_v, 2'b00);

        do_start(0);
        check_eq("zero_pass", pass_v, 2'b11);
        do_start(5);
        check_eq("over_code", fcode_v[1], 3);

        // randomized runs
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 5) == 0) do_reset();
            for (int e = 0; e < 4; e++) begin
                int adr_pool [4];
                adr_pool = '{96, 100, 104, 200};
                if ($urandom_range(0, 2) != 0)
                    do_cfg(e, adr_pool[$urandom_range(0, 3)], $urandom_range(0, 3));
            end
            do_start($urandom_range(0, 9) == 0 ? $urandom_range(0, 5) : $urandom_range(1, 4));
            for (int c = 0; c < 14; c++) begin
                int act;
                act = $urandom_range(0, 11);
                if (act <= 4) begin
                    int mm, ii;
                    mm = $urandom_range(0, 1);
                    ii = (act <= 2 && mcnt[mm] < 4) ? mcnt[mm] : $urandom_range(0, 3);
                    mem_write = 1; data_adr = tadr[mm][ii]; write_data = tdat[mm][ii];
                end else if (act == 5 || act == 6) begin
                    mem_write = 1; data_adr = 96; write_data = $urandom_range(0, 7);
                end else if (act == 7) begin
                    mem_write = 1; data_adr = 32'($urandom_range(0, 3) * 4 + 100);
                    write_data = $urandom_range(0, 3);
                end else if (act == 8) begin
                    cfg_we = 1; cfg_idx = 2'($urandom_range(0, 3));
                    cfg_adr = 100; cfg_data = $urandom_range(0, 3);
                end else if (act == 9 && $urandom_range(0, 3) == 0) begin
                    start = 1; num_exp = 3'($urandom_range(1, 4));
                end else if (act == 10 && $urandom_range(0, 7) == 0) begin
                    reset = 1;
                end
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
